// File: rtl/pipe_pkg.sv
// Shared types for the skid buffer pipeline stage: controller states and buffer depth.
package pipe_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_BUSY,
        SKID_FULL
    } skid_state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buffer_ctrl.sv
// Skid buffer controller: occupancy FSM driving the main/skid slot load enables.
// in_ready comes from state (and rst) only, so out_ready never reaches it combinationally.
module skid_buffer_ctrl
    import pipe_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    input  logic                              out_ready,
    output logic                              in_ready,
    output logic                              out_valid,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   count,
    output logic                              load_main,
    output logic                              load_skid,
    output logic                              sel_skid
);

    skid_state_t state_q, state_d;
    logic        in_xfer, out_xfer;

    assign in_ready  = !rst && (state_q != SKID_FULL);
    assign out_valid = (state_q != SKID_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        count = '0;
        case (state_q)
            SKID_BUSY: count = 2'd1;
            SKID_FULL: count = 2'd2;
            default:   count = 2'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        sel_skid  = 1'b0;
        // Flush drops everything, including a word offered this cycle.
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_xfer) begin
                        state_d   = SKID_BUSY;
                        load_main = 1'b1;
                    end
                end
                SKID_BUSY: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = SKID_FULL;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (out_xfer) begin
                        state_d   = SKID_BUSY;
                        load_main = 1'b1;
                        sel_skid  = 1'b1;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: 1-cycle latency, 1 word/cycle throughput.
// Downstream stalls are absorbed by the skid slot; in_ready drops only when both slots hold data.
module skid_buffer
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   count
);

    logic             load_main, load_skid, sel_skid;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q;

    skid_buffer_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .count     (count),
        .load_main (load_main),
        .load_skid (load_skid),
        .sel_skid  (sel_skid)
    );

    // Draining FULL refills main from the older skid word, keeping FIFO order.
    assign main_d = sel_skid ? skid_q : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) main_q <= main_d;
            if (load_skid) skid_q <= in_data;
        end
    end

    assign out_data = main_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Scenario bench for skid_buffer with a negedge scoreboard tracking ordering, loss and duplication.
module tb_skid_buffer;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  count;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    skid_buffer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    // Scoreboard: inputs are stable at negedge, so transfers seen here happen at the next posedge.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: emitted %08h, expected nothing", out_data);
                end else begin
                    logic [31:0] exp_w;
                    exp_w = sb_q.pop_front();
                    if (out_data !== exp_w) begin
                        failures++;
                        $display("FAIL sb_order: got %08h, expected %08h", out_data, exp_w);
                    end
                end
            end
            if (in_valid && in_ready) sb_q.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b1;
        repeat (3) tick();
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
        if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data: got %08h, expected 00000000", out_data); end
        if (count !== 2'd0) begin failures++; $display("FAIL rst_count: got %0d, expected 0", count); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready: got %b, expected 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_no_emit: out_valid %b, expected 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] words [3];
        words = '{32'h1234_5678, 32'hABCD_EF00, 32'hDEAD_BEEF};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i];
            tick();
            checks += 4;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d]: got %b, expected 1", i, out_valid); end
            if (out_data !== words[i]) begin failures++; $display("FAIL stream_data[%0d]: got %08h, expected %08h", i, out_data, words[i]); end
            if (count !== 2'd1) begin failures++; $display("FAIL stream_count[%0d]: got %0d, expected 1", i, count); end
            if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d]: got %b, expected 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (count !== 2'd0) begin failures++; $display("FAIL stream_drain_count: got %0d, expected 0", count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hCAFE_BABE;
        tick();
        in_data = 32'hFEED_FACE;
        tick();
        in_data = 32'h8765_4321;
        repeat (2) begin
            tick();
            checks += 3;
            if (count !== 2'd2) begin failures++; $display("FAIL bp_count: got %0d, expected 2", count); end
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b, expected 0", in_ready); end
            if (out_data !== 32'hCAFE_BABE) begin failures++; $display("FAIL bp_hold: got %08h, expected cafebabe", out_data); end
        end
        out_ready = 1'b1;
        tick();
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_drain1_valid: got %b, expected 1", out_valid); end
        if (out_data !== 32'hFEED_FACE) begin failures++; $display("FAIL bp_drain1_data: got %08h, expected feedface", out_data); end
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_drain2_valid: got %b, expected 1", out_valid); end
        if (out_data !== 32'h8765_4321) begin failures++; $display("FAIL bp_drain2_data: got %08h, expected 87654321", out_data); end
        tick();
        checks++;
        if (count !== 2'd0) begin failures++; $display("FAIL bp_empty: got %0d, expected 0", count); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0001;
        tick();
        in_data = 32'h8000_0000; out_ready = 1'b1;
        tick();
        checks += 2;
        if (count !== 2'd1) begin failures++; $display("FAIL sim_count: got %0d, expected 1", count); end
        if (out_data !== 32'h8000_0000) begin failures++; $display("FAIL sim_data: got %08h, expected 80000000", out_data); end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0002;
        tick();
        in_data = 32'h0000_0003;
        tick();
        checks++;
        if (count !== 2'd2) begin failures++; $display("FAIL sim_full_count: got %0d, expected 2", count); end
        in_data = 32'h0000_0004; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks += 3;
        if (count !== 2'd1) begin failures++; $display("FAIL sim_pop_count: got %0d, expected 1", count); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL sim_pop_in_ready: got %b, expected 1", in_ready); end
        if (out_data !== 32'h0000_0003) begin failures++; $display("FAIL sim_pop_data: got %08h, expected 00000003", out_data); end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hAAAA_0001;
        tick();
        in_data = 32'hAAAA_0002;
        tick();
        flush = 1'b1; in_data = 32'h1111_1111;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks += 2;
        if (count !== 2'd0) begin failures++; $display("FAIL flush_count: got %0d, expected 0", count); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b, expected 0", out_valid); end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h7FFF_FFFF;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_data !== 32'h7FFF_FFFF || out_valid !== 1'b1) begin
            failures++; $display("FAIL flush_next: got %08h/%b, expected 7fffffff/1", out_data, out_valid);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5555_0001;
        tick();
        in_data = 32'h5555_0002;
        tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        checks += 3;
        if (count !== 2'd0) begin failures++; $display("FAIL midrst_count: got %0d, expected 0", count); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b, expected 0", out_valid); end
        if (out_data !== 32'h0) begin failures++; $display("FAIL midrst_data: got %08h, expected 00000000", out_data); end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0000;
        tick();
        in_data = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL midrst_push: got %08h, expected ffffffff", out_data); end
        repeat (2) tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_reset_midop();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d words never emitted, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
